// File: rtl/bp_pkg.sv
// Shared constants and helpers for the fetch-stage branch predictor.
package bp_pkg;

    localparam int unsigned MAX_CTR_BITS = 4;
    localparam int unsigned MAX_IDX_BITS = 8;
    localparam int unsigned WIDE_PC_BITS = 64;

    typedef logic [WIDE_PC_BITS-1:0] wide_pc_t;

    // All-ones value of a counter of the given width.
    function automatic logic [MAX_CTR_BITS-1:0] ctr_max(input int unsigned bits);
        return MAX_CTR_BITS'((32'd1 << bits) - 32'd1);
    endfunction

    // Weakly-taken value: only the MSB set.
    function automatic logic [MAX_CTR_BITS-1:0] ctr_weak_taken(input int unsigned bits);
        return MAX_CTR_BITS'(32'd1 << (bits - 32'd1));
    endfunction

    // Low index_bits of the PC select the table entry.
    function automatic logic [MAX_IDX_BITS-1:0] pc_index(input wide_pc_t pc,
                                                        input int unsigned index_bits);
        wide_pc_t mask;
        mask = (wide_pc_t'(1) << index_bits) - wide_pc_t'(1);
        return MAX_IDX_BITS'(pc & mask);
    endfunction

    // Remaining upper PC bits form the tag.
    function automatic wide_pc_t pc_tag(input wide_pc_t pc, input int unsigned index_bits);
        return pc >> index_bits;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a saturating direction counter.
module sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur_value,
    input  logic         inc,
    input  logic         dec,
    input  logic         set_max,
    input  logic         load_weak,
    output logic [W-1:0] value_c
);

    localparam logic [W-1:0] MAX_VAL  = W'(ctr_max(W));
    localparam logic [W-1:0] WEAK_VAL = W'(ctr_weak_taken(W));

    // Priority: force-max, load-weak, then saturating step.
    always_comb begin
        value_c = cur_value;
        if (set_max) begin
            value_c = MAX_VAL;
        end else if (load_weak) begin
            value_c = WEAK_VAL;
        end else if (inc && (cur_value != MAX_VAL)) begin
            value_c = cur_value + W'(1);
        end else if (dec && (cur_value != '0)) begin
            value_c = cur_value - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_target,
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic                  update_taken,
    input  logic [PC_WIDTH-1:0]   update_target,
    input  logic                  update_uncond,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = PC_WIDTH - INDEX_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_WIDTH-1:0] target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t                table_q [ENTRIES];
    entry_t                table_d [ENTRIES];
    logic [STAT_WIDTH-1:0] count_q;
    logic [STAT_WIDTH-1:0] count_d;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    entry_t                lk_entry;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    entry_t                up_entry;
    logic                  up_hit;
    logic                  old_pred;
    logic                  mispredict;
    logic [CTR_BITS-1:0]   ctr_next;

    // Address split for both ports.
    always_comb begin
        lk_idx   = INDEX_BITS'(pc_index(wide_pc_t'(lookup_pc), INDEX_BITS));
        lk_tag   = TAG_W'(pc_tag(wide_pc_t'(lookup_pc), INDEX_BITS));
        up_idx   = INDEX_BITS'(pc_index(wide_pc_t'(update_pc), INDEX_BITS));
        up_tag   = TAG_W'(pc_tag(wide_pc_t'(update_pc), INDEX_BITS));
        lk_entry = table_q[lk_idx];
        up_entry = table_q[up_idx];
    end

    // Zero-latency lookup against current (pre-edge) table state.
    always_comb begin
        pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
        pred_taken  = pred_hit && lk_entry.ctr[CTR_BITS-1];
        pred_target = pred_hit ? lk_entry.target : '0;
    end

    // What the table would have predicted for the resolving instruction.
    always_comb begin
        up_hit     = up_entry.valid && (up_entry.tag == up_tag);
        old_pred   = up_hit && up_entry.ctr[CTR_BITS-1];
        mispredict = update_valid &&
                     ((update_taken != old_pred) ||
                      (update_taken && old_pred && (up_entry.target != update_target)));
    end

    sat_counter #(
        .W(CTR_BITS)
    ) u_ctr (
        .cur_value (up_entry.ctr),
        .inc       (up_hit && !update_uncond && update_taken),
        .dec       (up_hit && !update_uncond && !update_taken),
        .set_max   (update_uncond),
        .load_weak (!up_hit && !update_uncond && update_taken),
        .value_c   (ctr_next)
    );

    // Table write: update on hit, allocate on taken miss.
    always_comb begin
        table_d = table_q;
        if (update_valid) begin
            if (up_hit) begin
                table_d[up_idx].ctr = ctr_next;
                if (update_uncond || update_taken) begin
                    table_d[up_idx].target = update_target;
                end
            end else if (update_taken) begin
                table_d[up_idx].valid  = 1'b1;
                table_d[up_idx].tag    = up_tag;
                table_d[up_idx].target = update_target;
                table_d[up_idx].ctr    = ctr_next;
            end
        end
    end

    // Saturating mispredict statistic.
    always_comb begin
        count_d = count_q;
        if (mispredict && (count_q != '1)) begin
            count_d = count_q + STAT_WIDTH'(1);
        end
    end

    // Reset clears only valid bits; payload fields are don't-care until allocated.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Statistic register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

    localparam int unsigned PCW  = 32;
    localparam int unsigned IB   = 4;
    localparam int unsigned CB   = 2;
    localparam int unsigned SW   = 32;
    localparam int unsigned NENT = 16;
    localparam int CTR_TOP  = (1 << CB) - 1;
    localparam int CTR_HALF = 1 << (CB - 1);

    logic           clock;
    logic           reset;
    logic [PCW-1:0] lookup_pc;
    logic           pred_hit;
    logic           pred_taken;
    logic [PCW-1:0] pred_target;
    logic           update_valid;
    logic [PCW-1:0] update_pc;
    logic           update_taken;
    logic [PCW-1:0] update_target;
    logic           update_uncond;
    logic [SW-1:0]  mispredict_count;

    branch_predictor #(
        .PC_WIDTH(PCW), .INDEX_BITS(IB), .CTR_BITS(CB), .STAT_WIDTH(SW)
    ) dut (
        .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_uncond(update_uncond),
        .mispredict_count(mispredict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    bit          m_valid  [NENT];
    int unsigned m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_ctr    [NENT];
    logic [31:0] m_count;

    function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                     output bit tk, output logic [31:0] tgt);
        int unsigned i;
        i   = pc % NENT;
        hit = m_valid[i] && (m_tag[i] == pc / NENT);
        tk  = hit && (m_ctr[i] >= CTR_HALF);
        tgt = hit ? m_target[i] : 32'd0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit tk,
                                     input logic [31:0] tgt, input bit unc);
        bit          hit, ptk;
        logic [31:0] ptgt;
        int unsigned i;
        i = pc % NENT;
        m_lookup(pc, hit, ptk, ptgt);
        if ((tk != ptk) || (tk && ptk && ptgt != tgt)) begin
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
        if (hit) begin
            if (unc) m_ctr[i] = CTR_TOP;
            else if (tk) m_ctr[i] = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
            else m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            if (unc || tk) m_target[i] = tgt;
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = pc / NENT;
            m_target[i] = tgt;
            m_ctr[i]    = unc ? CTR_TOP : CTR_HALF;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check lookup/count before the edge, advance model.
    task automatic cycle(input bit rst, input logic [31:0] lk, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                         input bit uu, input bit chk);
        bit          h, t;
        logic [31:0] g;
        reset         = rst;
        lookup_pc     = lk;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utgt;
        update_uncond = uu;
        #1;
        if (chk) begin
            m_lookup(lk, h, t, g);
            check("pred_hit", 32'(pred_hit), 32'(h));
            check("pred_taken", 32'(pred_taken), 32'(t));
            check("pred_target", pred_target, g);
            check("mispredict_count", mispredict_count, m_count);
        end
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
            m_count = 32'd0;
        end else if (uv) begin
            m_update(upc, ut, utgt, uu);
        end
        @(negedge clock);
    endtask

    task automatic look(input logic [31:0] lk);
        cycle(1'b0, lk, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic upd(input logic [31:0] lk, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit uu);
        cycle(1'b0, lk, 1'b1, upc, ut, utgt, uu, 1'b1);
    endtask

    initial begin
        logic [31:0] lk, upc, tgt;
        bit          ut, uu, uv, rst;
        m_count = 32'd0;
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_ctr[i] = 0;
        end

        // Initial reset: table contents undefined beforehand, so no checks.
        cycle(1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Empty table.
        look(32'h10);

        // Cold unconditional jump.
        upd(32'h13, 32'h13, 1'b1, 32'h40, 1'b1);
        look(32'h13);

        // Conditional counter walk at 0x05.
        upd(32'h05, 32'h05, 1'b1, 32'h20, 1'b0);
        upd(32'h05, 32'h05, 1'b1, 32'h20, 1'b0);
        upd(32'h05, 32'h05, 1'b0, 32'h20, 1'b0);
        upd(32'h05, 32'h05, 1'b0, 32'h20, 1'b0);
        upd(32'h05, 32'h05, 1'b0, 32'h20, 1'b0);
        look(32'h05);
        check("count_after_walk", mispredict_count, 32'd4);

        // Alias on index 3.
        upd(32'h13, 32'h23, 1'b1, 32'h60, 1'b0);
        look(32'h13);
        look(32'h23);

        // Same-cycle lookup/update of index 3: old contents this cycle.
        upd(32'h23, 32'h13, 1'b1, 32'h77, 1'b1);
        look(32'h23);
        look(32'h13);

        // Target change on a strongly taken entry.
        upd(32'h07, 32'h07, 1'b1, 32'h40, 1'b1);
        upd(32'h07, 32'h07, 1'b1, 32'h44, 1'b0);
        look(32'h07);
        check("retarget", pred_target, 32'h44);

        // Reset with a concurrent update: discarded.
        cycle(1'b1, 32'h13, 1'b1, 32'h09, 1'b1, 32'h99, 1'b1, 1'b1);
        look(32'h09);
        look(32'h13);
        check("count_after_reset", mispredict_count, 32'd0);

        // Randomized traffic with small pc/target pools to force aliasing and retargets.
        for (int n = 0; n < 400; n++) begin
            upc = {26'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            lk  = ($urandom_range(0, 3) == 0) ? upc
                : {26'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            uv  = ($urandom_range(0, 2) != 0);
            uu  = ($urandom_range(0, 4) == 0);
            ut  = uu ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h44;
            rst = ($urandom_range(0, 59) == 0);
            cycle(rst, lk, uv, upc, ut, tgt, uu, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
